// File: rtl/branch_resolver.sv
// Branch resolution: computes the actual outcome of control-flow instructions,
// raises a registered mispredict/redirect with a timed flush, and queues BTB updates.
module branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned UQ_DEPTH     = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_valid,
    input  logic [1:0]  ex_type,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] ex_rs1,
    input  logic        ex_cond,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    input  logic        btb_busy,
    output logic [31:0] pc_res,
    output logic [31:0] bt_res,
    output logic        enable_res,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] br_count,
    output logic [31:0] mp_count,
    output logic        uq_overflow
);

    localparam int unsigned PW = $clog2(UQ_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned FW = 3;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_next;

    logic          accepted_c;
    logic          taken_c;
    logic [31:0]   target_c;
    logic [31:0]   redirect_c;
    logic          mp_c;
    logic          push_c;
    logic          pop_c;
    logic          full_c;
    logic          push_ok_c;
    logic          drop_c;

    logic [31:0]   pc_q [UQ_DEPTH];
    logic [31:0]   bt_q [UQ_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Resolve actual direction/target and compare against the fetch prediction
    always_comb begin
        taken_c  = 1'b0;
        target_c = '0;
        unique case (ex_type)
            2'b01: begin
                taken_c  = ex_cond;
                target_c = ex_pc + ex_imm;
            end
            2'b10: begin
                taken_c  = 1'b1;
                target_c = ex_pc + ex_imm;
            end
            2'b11: begin
                taken_c  = 1'b1;
                target_c = (ex_rs1 + ex_imm) & ~32'd1;
            end
            default: begin
                taken_c  = 1'b0;
                target_c = '0;
            end
        endcase
        accepted_c = ex_valid && (ex_type != 2'b00) && !flush;
        redirect_c = taken_c ? target_c : ex_pc + 32'd4;
        mp_c       = accepted_c &&
                     ((taken_c != ex_pred_taken) ||
                      (taken_c && (ex_pred_target != target_c)));
        push_c     = accepted_c && taken_c;
    end

    // Flush sequencing
    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        unique case (state)
            IDLE: begin
                if (mp_c) begin
                    state_next = FLUSH;
                    fcnt_next  = FW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (fcnt == '0) begin
                    state_next = IDLE;
                end else begin
                    fcnt_next = fcnt - FW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            fcnt        <= '0;
            flush       <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            br_count    <= '0;
            mp_count    <= '0;
        end else begin
            state       <= state_next;
            fcnt        <= fcnt_next;
            flush       <= (state_next == FLUSH);
            mispredict  <= mp_c;
            redirect_pc <= mp_c ? redirect_c : '0;
            if (accepted_c && (br_count != '1)) begin
                br_count <= br_count + 32'd1;
            end
            if (mp_c && (mp_count != '1)) begin
                mp_count <= mp_count + 32'd1;
            end
        end
    end

    // BTB update queue; a pop frees the head slot so a push into a full queue still fits
    always_comb begin
        full_c     = (count == CW'(UQ_DEPTH));
        pop_c      = (count != '0) && !btb_busy;
        push_ok_c  = push_c && (!full_c || pop_c);
        drop_c     = push_c && full_c && !pop_c;
        enable_res = pop_c;
        pc_res     = pc_q[head];
        bt_res     = bt_q[head];
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            uq_overflow <= 1'b0;
            for (int i = 0; i < int'(UQ_DEPTH); i++) begin
                pc_q[i] <= '0;
                bt_q[i] <= '0;
            end
        end else begin
            if (push_ok_c) begin
                pc_q[tail] <= ex_pc;
                bt_q[tail] <= target_c;
                tail       <= tail + PW'(1);
            end
            if (pop_c) begin
                head <= head + PW'(1);
            end
            if (push_ok_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (!push_ok_c && pop_c) begin
                count <= count - CW'(1);
            end
            if (drop_c) begin
                uq_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized and directed bench for branch_resolver, checked against a queue-based reference model.
module tb_branch_resolver;

    localparam int unsigned FC    = 2;
    localparam int unsigned DEPTH = 4;

    logic        CLK;
    logic        nRST;
    logic        ex_valid;
    logic [1:0]  ex_type;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        ex_cond;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        btb_busy;
    logic [31:0] pc_res;
    logic [31:0] bt_res;
    logic        enable_res;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mp_count;
    logic        uq_overflow;

    branch_resolver #(.FLUSH_CYCLES(FC), .UQ_DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .ex_valid(ex_valid), .ex_type(ex_type),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_cond(ex_cond),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .btb_busy(btb_busy), .pc_res(pc_res), .bt_res(bt_res),
        .enable_res(enable_res), .mispredict(mispredict), .redirect_pc(redirect_pc),
        .flush(flush), .br_count(br_count), .mp_count(mp_count),
        .uq_overflow(uq_overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bt;
    } ent_t;

    // Reference model state, as seen by the pipeline in the current cycle
    ent_t        mq[$];
    int          m_flush_left;
    logic        m_mis;
    logic [31:0] m_redir;
    logic [31:0] m_br;
    logic [31:0] m_mp;
    logic        m_ovf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_taken(input logic [1:0] t, input logic c);
        return (t == 2'b01) ? c : (t >= 2'b10);
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] pc,
                                               input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] s;
        if (t == 2'b11) begin
            s = rs1 + imm;
            s[0] = 1'b0;
            return s;
        end
        return pc + imm;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_mis        = 1'b0;
        m_redir      = '0;
        m_br         = '0;
        m_mp         = '0;
        m_ovf        = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs applied now
    task automatic model_step();
        logic        acc, tk, mp, pop;
        logic [31:0] tgt;
        ent_t        e;
        if (!nRST) begin
            model_reset();
            return;
        end
        acc = ex_valid && (ex_type != 2'b00) && (m_flush_left == 0);
        tk  = ref_taken(ex_type, ex_cond);
        tgt = ref_target(ex_type, ex_pc, ex_imm, ex_rs1);
        mp  = acc && ((tk != ex_pred_taken) || (tk && (tgt != ex_pred_target)));
        pop = (mq.size() > 0) && !btb_busy;
        if (acc && tk && (mq.size() == int'(DEPTH)) && !pop) m_ovf = 1'b1;
        if (pop) void'(mq.pop_front());
        if (acc && tk && (mq.size() < int'(DEPTH))) begin
            e.pc = ex_pc;
            e.bt = tgt;
            mq.push_back(e);
        end
        if (m_flush_left > 0) m_flush_left--;
        if (mp) m_flush_left = int'(FC);
        m_mis   = mp;
        m_redir = tk ? tgt : ex_pc + 32'd4;
        if (acc && (m_br != 32'hFFFF_FFFF)) m_br++;
        if (mp && (m_mp != 32'hFFFF_FFFF)) m_mp++;
    endtask

    task automatic compare_model();
        chk("mispredict", 32'(mispredict), 32'(m_mis));
        if (m_mis) chk("redirect_pc", redirect_pc, m_redir);
        chk("flush", 32'(flush), 32'(m_flush_left > 0));
        chk("enable_res", 32'(enable_res), 32'((mq.size() > 0) && !btb_busy));
        if (mq.size() > 0) begin
            chk("pc_res", pc_res, mq[0].pc);
            chk("bt_res", bt_res, mq[0].bt);
        end
        chk("br_count", br_count, m_br);
        chk("mp_count", mp_count, m_mp);
        chk("uq_overflow", 32'(uq_overflow), 32'(m_ovf));
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic cond,
                         input logic pt, input logic [31:0] ptgt, input logic busy);
        ex_valid       = v;
        ex_type        = t;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_rs1         = rs1;
        ex_cond        = cond;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        btb_busy       = busy;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, clock both
    task automatic cyc(input logic v, input logic [1:0] t, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic cond,
                       input logic pt, input logic [31:0] ptgt, input logic busy);
        drive(v, t, pc, imm, rs1, cond, pt, ptgt, busy);
        #1;
        compare_model();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic busy);
        cyc(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, busy);
    endtask

    task automatic good_br(input logic [31:0] pc, input logic [31:0] imm, input logic busy);
        cyc(1'b1, 2'b01, pc, imm, '0, 1'b1, 1'b1, pc + imm, busy);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle(1'b0);
        idle(1'b0);
        nRST = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] pc, imm, rs1, ptgt;
        logic [1:0]  t;
        logic        busy;

        nRST = 1'b0;
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_pc_res", pc_res, 32'h0);
        chk("rst_bt_res", bt_res, 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_enable", 32'(enable_res), 32'h0);
        chk("rst_ovf", 32'(uq_overflow), 32'h0);
        do_reset();

        // Correctly predicted taken branch
        good_br(32'h100, 32'h40, 1'b0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d1_mispredict", 32'(mispredict), 32'h0);
        chk("d1_enable", 32'(enable_res), 32'h1);
        chk("d1_pc_res", pc_res, 32'h100);
        chk("d1_bt_res", bt_res, 32'h140);
        chk("d1_br_count", br_count, 32'h1);
        idle(1'b0);

        // Not-taken branch predicted taken: redirect to pc+4, flush ignores new work
        cyc(1'b1, 2'b01, 32'h200, 32'h80, '0, 1'b0, 1'b1, 32'h280, 1'b0);
        drive(1'b1, 2'b10, 32'h300, 32'h8, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d2_mispredict", 32'(mispredict), 32'h1);
        chk("d2_redirect", redirect_pc, 32'h204);
        chk("d2_flush_a", 32'(flush), 32'h1);
        chk("d2_mp_count", mp_count, 32'h1);
        cyc(1'b1, 2'b10, 32'h300, 32'h8, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b1, 2'b10, 32'h310, 32'h8, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d2_flush_b", 32'(flush), 32'h1);
        chk("d2_mis_one_cycle", 32'(mispredict), 32'h0);
        cyc(1'b1, 2'b10, 32'h310, 32'h8, '0, 1'b0, 1'b0, '0, 1'b0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d2_flush_end", 32'(flush), 32'h0);
        chk("d2_br_count", br_count, 32'h2);
        chk("d2_ignored_enable", 32'(enable_res), 32'h0);
        idle(1'b0);

        // JALR clears bit 0 of the target
        cyc(1'b1, 2'b11, 32'h400, 32'h10, 32'h1001, 1'b0, 1'b1, 32'h1010, 1'b0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d3_mispredict", 32'(mispredict), 32'h0);
        chk("d3_bt_res", bt_res, 32'h1010);
        idle(1'b0);

        // Five taken branches while BTB is busy: fifth dropped, then drain in order
        for (int i = 0; i < 5; i++) good_br(32'h1000 + 32'(i) * 32'h10, 32'h20, 1'b1);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        chk("d4_overflow", 32'(uq_overflow), 32'h1);
        chk("d4_busy_enable", 32'(enable_res), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            chk("d4_drain_en", 32'(enable_res), 32'h1);
            chk("d4_drain_pc", pc_res, 32'h1000 + 32'(i) * 32'h10);
            idle(1'b0);
        end
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d4_empty", 32'(enable_res), 32'h0);

        // Full queue, pop and push in the same cycle: no overflow
        do_reset();
        for (int i = 0; i < 4; i++) good_br(32'h2000 + 32'(i) * 32'h10, 32'h20, 1'b1);
        good_br(32'h3000, 32'h20, 1'b0);
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        #1;
        chk("d5_no_overflow", 32'(uq_overflow), 32'h0);
        chk("d5_head", pc_res, 32'h2010);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Reset during flush with entries queued discards everything
        good_br(32'h4000, 32'h20, 1'b1);
        good_br(32'h4010, 32'h20, 1'b1);
        cyc(1'b1, 2'b01, 32'h4020, 32'h20, '0, 1'b0, 1'b1, 32'h4040, 1'b1);
        nRST = 1'b0;
        idle(1'b1);
        nRST = 1'b1;
        drive(1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        chk("d6_flush", 32'(flush), 32'h0);
        chk("d6_enable", 32'(enable_res), 32'h0);
        chk("d6_br_count", br_count, 32'h0);
        chk("d6_mp_count", mp_count, 32'h0);

        // Random traffic with bursty BTB back-pressure and occasional resets
        for (int i = 0; i < 3000; i++) begin
            r    = $urandom;
            t    = 2'($urandom_range(0, 3));
            pc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            imm  = {{20{r[11]}}, r[11:0]};
            rs1  = $urandom;
            ptgt = ($urandom_range(0, 3) == 0) ? $urandom : ref_target(t, pc, imm, rs1);
            busy = (i[8]) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            nRST = ($urandom_range(0, 299) != 0);
            cyc($urandom_range(0, 3) != 0, t, pc, imm, rs1, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), ptgt, busy);
        end
        nRST = 1'b1;
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
